// File: rtl/pc_sequencer_if.sv
// Host/decoder-side bundle for the PC sequencer: control inputs in,
// registered PC/status out.
interface pc_sequencer_if #(
  parameter int PW = 10,
  parameter int CW = 16
);
  logic          Start;
  logic          Halt;
  logic          Stall;
  logic          Branch;
  logic          Zero;
  logic [PW-1:0] Target;
  logic [PW-1:0] PC;
  logic          Taken;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Retired;

  // Host / decode side drives control and observes status.
  modport master (
    output Start, Halt, Stall, Branch, Zero, Target,
    input  PC, Taken, Busy, Done, Retired
  );

  // Sequencer side.
  modport slave (
    input  Start, Halt, Stall, Branch, Zero, Target,
    output PC, Taken, Busy, Done, Retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: arm on Start, launch on Start's falling edge,
// step/stall/branch/halt in RUN, with a saturating retired-instruction count.
// Every output is a register or a decode of the state register.
module pc_sequencer #(
  parameter int PW = 10,
  parameter int CW = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q,    pc_d;
  logic [CW-1:0] ret_q,   ret_d;
  logic          taken_q, taken_d;
  logic [CW-1:0] ret_inc;

  // Retired count sticks at all-ones instead of wrapping.
  assign ret_inc = (ret_q == {CW{1'b1}}) ? ret_q : ret_q + 1'b1;

  // State and datapath registers; Reset dominates everything.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      taken_q <= taken_d;
    end
  end

  // Next state and datapath; decoder inputs only matter in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    taken_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = ARMED;
          pc_d    = '0;
          ret_d   = '0;
        end
      end
      ARMED: begin
        // PC pinned at 0 so the first fetch after launch is address 0.
        pc_d  = '0;
        ret_d = '0;
        if (!bus.Start) state_d = RUN;
      end
      RUN: begin
        if (bus.Start) begin
          state_d = ARMED;
          pc_d    = '0;
          ret_d   = '0;
        end else if (bus.Halt) begin
          // The halt instruction itself counts as retired.
          state_d = DONE;
          ret_d   = ret_inc;
        end else if (bus.Stall) begin
          // Multi-cycle op in flight: hold PC and count.
        end else if (bus.Branch && bus.Zero) begin
          pc_d    = bus.Target;
          taken_d = 1'b1;
          ret_d   = ret_inc;
        end else begin
          pc_d  = pc_q + 1'b1;
          ret_d = ret_inc;
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d = ARMED;
          pc_d    = '0;
          ret_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.PC      = pc_q;
  assign bus.Retired = ret_q;
  assign bus.Taken   = taken_q;
  assign bus.Busy    = (state_q == RUN);
  assign bus.Done    = (state_q == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: two sequencers (wide and narrow retired counter) share
// one stimulus stream; a cycle-level reference model queues the expected
// outputs and a negedge monitor pops and compares them.
module tb_pc_sequencer;
  localparam int PW  = 10;
  localparam int CWA = 16;
  localparam int CWB = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start, halt, stall, branch, zero;
  logic [PW-1:0] target;

  pc_sequencer_if #(.PW(PW), .CW(CWA)) bus_a ();
  pc_sequencer_if #(.PW(PW), .CW(CWB)) bus_b ();

  assign bus_a.Start = start;  assign bus_b.Start = start;
  assign bus_a.Halt = halt;    assign bus_b.Halt = halt;
  assign bus_a.Stall = stall;  assign bus_b.Stall = stall;
  assign bus_a.Branch = branch; assign bus_b.Branch = branch;
  assign bus_a.Zero = zero;    assign bus_b.Zero = zero;
  assign bus_a.Target = target; assign bus_b.Target = target;

  pc_sequencer #(.PW(PW), .CW(CWA)) dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
  pc_sequencer #(.PW(PW), .CW(CWB)) dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));

  always #5 Clk = ~Clk;

  typedef struct {
    int pc;
    int taken;
    int busy;
    int done;
    int ret;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: plain integers, retired kept unbounded and clipped
  // to each counter width only when compared.
  typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mstate_t;
  mstate_t m_st  = M_IDLE;
  int      m_pc  = 0;
  int      m_ret = 0;
  int      m_tk  = 0;

  task automatic cyc(input int rst_n, input int st, input int h, input int s,
                     input int b, input int z, input int tgt);
    Reset  = (rst_n != 0);
    start  = (st != 0);
    halt   = (h != 0);
    stall  = (s != 0);
    branch = (b != 0);
    zero   = (z != 0);
    target = PW'(tgt);
    m_tk = 0;
    if (rst_n == 0) begin
      m_st = M_IDLE; m_pc = 0; m_ret = 0;
    end else begin
      case (m_st)
        M_IDLE:  if (st != 0) begin m_st = M_ARMED; m_pc = 0; m_ret = 0; end
        M_ARMED: if (st == 0) m_st = M_RUN;
        M_RUN: begin
          if (st != 0) begin
            m_st = M_ARMED; m_pc = 0; m_ret = 0;
          end else if (h != 0) begin
            m_st = M_DONE; m_ret++;
          end else if (s != 0) begin
            // hold
          end else if (b != 0 && z != 0) begin
            m_pc = tgt % (1 << PW); m_tk = 1; m_ret++;
          end else begin
            m_pc = (m_pc + 1) % (1 << PW); m_ret++;
          end
        end
        M_DONE:  if (st != 0) begin m_st = M_ARMED; m_pc = 0; m_ret = 0; end
        default: m_st = M_IDLE;
      endcase
    end
    q.push_back('{m_pc, m_tk, int'(m_st == M_RUN), int'(m_st == M_DONE), m_ret});
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: outputs are valid every cycle, one queued entry per edge.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("A.PC",      int'(bus_a.PC),      e.pc);
      chk("A.Taken",   int'(bus_a.Taken),   e.taken);
      chk("A.Busy",    int'(bus_a.Busy),    e.busy);
      chk("A.Done",    int'(bus_a.Done),    e.done);
      chk("A.Retired", int'(bus_a.Retired), sat(e.ret, CWA));
      chk("B.PC",      int'(bus_b.PC),      e.pc);
      chk("B.Taken",   int'(bus_b.Taken),   e.taken);
      chk("B.Busy",    int'(bus_b.Busy),    e.busy);
      chk("B.Done",    int'(bus_b.Done),    e.done);
      chk("B.Retired", int'(bus_b.Retired), sat(e.ret, CWB));
    end
  end

  initial begin
    int guard;
    // Reset, including Start held during reset.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 1, 5);
    // Launch: Start high 3 cycles, then low.
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_pc != 5 && guard < 20) begin step(1); guard++; end
    chk("reach_pc5", m_pc, 5);
    // Taken branch, back to 5, then not-taken branch.
    cyc(1, 0, 0, 0, 1, 1, 'h2A);
    cyc(1, 0, 0, 0, 1, 1, 5);
    cyc(1, 0, 0, 0, 1, 0, 'h2A);
    step(1);
    // Stall at PC 7 (one stall cycle also carries a taken branch).
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 1, 'h33);
    cyc(1, 0, 0, 1, 0, 0, 0);
    // Halt beats stall and branch.
    cyc(1, 0, 1, 1, 1, 1, 'h55);
    // Decoder inputs ignored in DONE.
    for (int i = 0; i < 3; i++)
      cyc(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, $urandom_range(0, 1023));
    // Restart from DONE, launch, wrap PC at all-ones.
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 'h3FF);
    step(1);
    // Enough retirements to saturate the narrow counter.
    step(20);
    // Restart mid-RUN at PC 0x10.
    cyc(1, 0, 0, 0, 1, 1, 'h10);
    cyc(1, 1, 0, 0, 1, 1, 'h20);
    cyc(1, 0, 0, 0, 0, 0, 0);
    step(3);
    // Reset mid-RUN with Start and a taken branch.
    cyc(0, 1, 0, 0, 1, 1, 'h3);
    // Stay IDLE without Start regardless of decoder inputs.
    for (int i = 0; i < 4; i++)
      cyc(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, $urandom_range(0, 1023));
    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      cyc(int'($urandom_range(0, 99) != 0),
          int'($urandom_range(0, 24) == 0),
          int'($urandom_range(0, 39) == 0),
          int'($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 1) == 0),
          $urandom_range(0, 1023));
    end
    repeat (2) @(negedge Clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: PW, default 10, program counter width in bits.
REQ-002 Parameter: CW, default 16, retired-instruction counter width in bits.
REQ-003 Port: Clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-low reset; sampled on rising Clk only.
REQ-005 Port: Start  input  1  host request; high arms/restarts, its falling edge launches execution.
REQ-006 Port: Halt  input  1  decoded halt instruction at current PC.
REQ-007 Port: Stall  input  1  hold PC this cycle (multi-cycle op in flight).
REQ-008 Port: Branch  input  1  decoded conditional branch (BEQ) at current PC.
REQ-009 Port: Zero  input  1  ALU equality flag, same cycle as Branch.
REQ-010 Port: Target  input  PW  absolute branch target from the branch LUT.
REQ-011 Port: PC  output  PW  current instruction address.
REQ-012 Port: Taken  output  1  registered one-cycle pulse: branch taken last cycle.
REQ-013 Port: Busy  output  1  high in RUN state.
REQ-014 Port: Done  output  1  high in DONE state.
REQ-015 Port: Retired  output  CW  count of instructions retired since launch.

Function
REQ-016 FSM states SHALL be IDLE, ARMED, RUN, DONE; Busy and Done SHALL be Moore decodes of state.
REQ-017 IDLE: Start=1 -> ARMED, PC<=0, Retired<=0; else hold.
REQ-018 ARMED: Start=1 -> hold (PC=0); Start=0 -> RUN; PC remains 0 so first fetch is address 0.
REQ-019 RUN priority, highest first: Start=1, Halt, Stall, Branch&&Zero, default.
REQ-020 RUN, Start=1: -> ARMED, PC<=0, Retired<=0 (restart mid-run); Taken<=0.
REQ-021 RUN, Halt=1: -> DONE, PC held, Retired+1 (halt retires).
REQ-022 RUN, Stall=1 (no Halt): PC held, Retired held, Taken<=0.
REQ-023 RUN, Branch=1 and Zero=1: PC<=Target, Taken<=1, Retired+1.
REQ-024 RUN, Branch=1 and Zero=0: PC<=PC+1, Taken<=0, Retired+1.
REQ-025 RUN default: PC<=PC+1 modulo 2^PW (all-ones wraps to 0), Retired+1.
REQ-026 Retired SHALL saturate at all-ones, never wrap.
REQ-027 DONE: PC and Retired held; Start=1 -> ARMED, PC<=0, Retired<=0; Done deasserts the cycle after.
REQ-028 Halt, Stall, Branch, Zero SHALL be ignored outside RUN.
REQ-029 Taken SHALL be 0 in every state except the cycle after a taken branch in RUN.
REQ-030 No combinational path from any input to any output; all outputs registered or state-decoded.
REQ-031 Zero and Branch are consumed same cycle as produced by ALU/decoder; latency input->PC is exactly one Clk.

Reset
REQ-032 Reset=0 at a rising edge SHALL force: state IDLE, PC=0, Retired=0, Taken=0, Busy=0, Done=0.
REQ-033 Reset SHALL dominate Start and all RUN events in the same cycle, including mid-RUN and in DONE.
REQ-034 After Reset returns high, block SHALL stay IDLE until Start=1 sampled.

Verification
REQ-035 Launch: Reset low 2 cycles, Start high 3 cycles then low, no Halt -> PC 0,0,1,2,3 on successive cycles after Start falls; Busy=1; Retired tracks PC.
REQ-036 Branch: in RUN at PC=5, Branch=1 Zero=1 Target=0x2A -> next PC=0x2A, Taken=1 one cycle; Branch=1 Zero=0 at PC=5 -> PC=6, Taken=0.
REQ-037 Priority/stall: Stall=1 for 3 cycles at PC=7 -> PC stays 7, Retired unchanged; Halt=1 with Stall=1 and Branch&&Zero -> DONE, PC=7, Done=1.
REQ-038 Wrap/saturate: PW=10, PC=0x3FF default step -> PC=0x000; CW=4 run 20 instructions -> Retired=0xF.
REQ-039 Restart: Start=1 mid-RUN at PC=0x10 -> ARMED, PC=0, Retired=0; Start=1 in DONE -> ARMED, Done=0 next cycle.
REQ-040 Reset mid-run: Reset=0 with Start=1 and Branch&&Zero in RUN -> IDLE, all outputs 0 next cycle.
